// File: rtl/rnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rnn_pkg
//  Description : Shared widths, state encoding, buffer selects and constants
//                for the 3x3 simple-RNN host controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package rnn_pkg;

    // Word and vector geometry
    localparam int DATA_W = 32;
    localparam int N_ELEM = 9;
    localparam int ADDR_W = 4;

    // Controller state encoding (IDLE, SEND, WAIT, RECV, DONE)
    typedef logic [2:0] rnn_state_t;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_RECV = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // cfg_sel encodings
    localparam logic [1:0] SEL_U = 2'd0;
    localparam logic [1:0] SEL_W = 2'd1;
    localparam logic [1:0] SEL_V = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;

    // IEEE-754 +0.0, driven on the data buses while valids are low
    localparam logic [DATA_W-1:0] FP_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/rnn_vec_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rnn_vec_buf
//  Description : DEPTH x WIDTH register file, one write port, one
//                combinational read port. Out-of-range writes are dropped,
//                out-of-range reads return zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rnn_vec_buf
    import rnn_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = N_ELEM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage: cleared on reset, one element written per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (we && (waddr == ADDR_W'(e))) r_mem[e] <= wdata;
            end
        end
    end

    // Read mux: any address past the last element reads as zero
    always_comb begin
        rdata = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (raddr == ADDR_W'(e)) rdata = r_mem[e];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rnn_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rnn_host_ctrl
//  Description : Host-side driver/collector for the 3x3 simple-RNN
//                accelerator. Streams one U/W/V/X frame as a 9-beat burst and
//                captures the 9-beat result burst into a readable buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rnn_host_ctrl
    import rnn_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              frame_err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              in_valid_u,
    output logic              in_valid_w,
    output logic              in_valid_v,
    output logic              in_valid_x,
    output logic [DATA_W-1:0] weight_u,
    output logic [DATA_W-1:0] weight_w,
    output logic [DATA_W-1:0] weight_v,
    output logic [DATA_W-1:0] data_x,
    input  logic              out_valid,
    input  logic [DATA_W-1:0] out
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    rnn_state_t          r_state;
    logic [ADDR_W-1:0]   r_idx;       // next element to put on the bus
    logic [ADDR_W-1:0]   r_k;         // next result slot to capture
    logic [c_CNT_W-1:0]  r_wait_cnt;
    logic                r_valid;
    logic [DATA_W-1:0]   r_wu, r_ww, r_wv, r_wx;
    logic                r_busy, r_done, r_to_err, r_fr_err;
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_cfg_ok;
    logic [ADDR_W-1:0]   w_src_idx;
    logic [DATA_W-1:0]   w_u, w_w, w_v, w_x, w_res_rd;
    logic                w_res_we;
    logic [ADDR_W-1:0]   w_res_addr;

    // Buffer write qualification, send index and result capture steering
    always_comb begin
        w_cfg_ok   = cfg_we && (r_state == ST_IDLE);
        // In IDLE the start edge loads element 0 straight onto the bus
        w_src_idx  = (r_state == ST_IDLE) ? '0 : r_idx;
        w_res_we   = out_valid && ((r_state == ST_WAIT) || (r_state == ST_RECV));
        w_res_addr = (r_state == ST_WAIT) ? '0 : r_k;
    end

    rnn_vec_buf u_buf_u (
        .clk(clk), .rst_n(rst_n), .we(w_cfg_ok && (cfg_sel == SEL_U)),
        .waddr(cfg_addr), .wdata(cfg_wdata), .raddr(w_src_idx), .rdata(w_u)
    );
    rnn_vec_buf u_buf_w (
        .clk(clk), .rst_n(rst_n), .we(w_cfg_ok && (cfg_sel == SEL_W)),
        .waddr(cfg_addr), .wdata(cfg_wdata), .raddr(w_src_idx), .rdata(w_w)
    );
    rnn_vec_buf u_buf_v (
        .clk(clk), .rst_n(rst_n), .we(w_cfg_ok && (cfg_sel == SEL_V)),
        .waddr(cfg_addr), .wdata(cfg_wdata), .raddr(w_src_idx), .rdata(w_v)
    );
    rnn_vec_buf u_buf_x (
        .clk(clk), .rst_n(rst_n), .we(w_cfg_ok && (cfg_sel == SEL_X)),
        .waddr(cfg_addr), .wdata(cfg_wdata), .raddr(w_src_idx), .rdata(w_x)
    );
    rnn_vec_buf u_buf_res (
        .clk(clk), .rst_n(rst_n), .we(w_res_we),
        .waddr(w_res_addr), .wdata(out), .raddr(rd_addr), .rdata(w_res_rd)
    );

    // Frame sequencing plus all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_k        <= '0;
            r_wait_cnt <= '0;
            r_valid    <= 1'b0;
            r_wu       <= FP_ZERO;
            r_ww       <= FP_ZERO;
            r_wv       <= FP_ZERO;
            r_wx       <= FP_ZERO;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_to_err   <= 1'b0;
            r_fr_err   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_data <= w_res_rd;
            // done is raised on the cycle after DONE, as DONE hands back to IDLE
            r_done    <= (r_state == ST_DONE);
            r_valid   <= 1'b0;
            r_wu      <= FP_ZERO;
            r_ww      <= FP_ZERO;
            r_wv      <= FP_ZERO;
            r_wx      <= FP_ZERO;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_to_err <= 1'b0;
                        r_fr_err <= 1'b0;
                        r_valid  <= 1'b1;
                        r_wu     <= w_u;
                        r_ww     <= w_w;
                        r_wv     <= w_v;
                        r_wx     <= w_x;
                        r_idx    <= ADDR_W'(1);
                        r_busy   <= 1'b1;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (r_idx == ADDR_W'(N_ELEM)) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_valid <= 1'b1;
                        r_wu    <= w_u;
                        r_ww    <= w_w;
                        r_wv    <= w_v;
                        r_wx    <= w_x;
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (out_valid) begin
                        r_k     <= ADDR_W'(1);
                        r_state <= ST_RECV;
                    end else if (r_wait_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        r_to_err <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_RECV: begin
                    if (out_valid) begin
                        if (r_k == ADDR_W'(N_ELEM - 1)) r_state <= ST_DONE;
                        else                            r_k     <= r_k + 1'b1;
                    end else begin
                        r_fr_err <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_to_err;
    assign frame_err   = r_fr_err;
    assign rd_data     = r_rd_data;
    assign in_valid_u  = r_valid;
    assign in_valid_w  = r_valid;
    assign in_valid_v  = r_valid;
    assign in_valid_x  = r_valid;
    assign weight_u    = r_wu;
    assign weight_w    = r_ww;
    assign weight_v    = r_wv;
    assign data_x      = r_wx;

endmodule
`default_nettype wire

// File: tb/tb_rnn_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rnn_host_ctrl
//  Description : Directed self-checking bench for rnn_host_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rnn_host_ctrl;

    localparam logic [31:0] c_U = 32'h3F80_0000;
    localparam logic [31:0] c_W = 32'h4000_0000;
    localparam logic [31:0] c_V = 32'h4040_0000;

    logic        clk = 1'b0;
    logic        rst_n, cfg_we, start, out_valid;
    logic [1:0]  cfg_sel;
    logic [3:0]  cfg_addr, rd_addr;
    logic [31:0] cfg_wdata, acc_out;
    logic        busy, done, timeout_err, frame_err;
    logic [31:0] rd_data, weight_u, weight_w, weight_v, data_x;
    logic        in_valid_u, in_valid_w, in_valid_v, in_valid_x;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    rnn_host_ctrl #(.TIMEOUT(63)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .start(start),
        .busy(busy), .done(done), .timeout_err(timeout_err), .frame_err(frame_err),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .in_valid_u(in_valid_u), .in_valid_w(in_valid_w),
        .in_valid_v(in_valid_v), .in_valid_x(in_valid_x),
        .weight_u(weight_u), .weight_w(weight_w), .weight_v(weight_v), .data_x(data_x),
        .out_valid(out_valid), .out(acc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_burst(input int i, input logic [31:0] eu, input logic [31:0] ew,
                             input logic [31:0] ev, input logic [31:0] ex);
        check($sformatf("valids[%0d]", i),
              {28'd0, in_valid_u, in_valid_w, in_valid_v, in_valid_x}, 32'hF);
        check($sformatf("weight_u[%0d]", i), weight_u, eu);
        check($sformatf("weight_w[%0d]", i), weight_w, ew);
        check($sformatf("weight_v[%0d]", i), weight_v, ev);
        check($sformatf("data_x[%0d]", i), data_x, ex);
        check($sformatf("busy_send[%0d]", i), {31'd0, busy}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; rd_addr = '0; out_valid = 1'b0; acc_out = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_errs", {30'd0, timeout_err, frame_err}, 0);
        check("rst_valid", {31'd0, in_valid_u}, 0);
        check("rst_weight_u", weight_u, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load U/W/V/X
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 9; i++) begin
                cfg_we    = 1'b1;
                cfg_sel   = s[1:0];
                cfg_addr  = i[3:0];
                cfg_wdata = (s == 0) ? c_U : (s == 1) ? c_W : (s == 2) ? c_V : 32'(i);
                @(negedge clk);
            end
        end
        cfg_we = 1'b0;

        // Frame 1: burst, with start/cfg_we poked mid-SEND
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_burst(i, c_U, c_W, c_V, 32'(i));
            if (i == 3) begin
                start = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 4'd0;
                cfg_wdata = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; cfg_we = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check("post_valid", {31'd0, in_valid_u}, 0);
            check("post_bus", weight_u | weight_w | weight_v | data_x, 0);
            check("wait_busy", {31'd0, busy}, 1);
            @(negedge clk);
        end
        // Ten result beats; poke start/cfg_we during RECV; tenth beat must be ignored
        for (int k = 0; k < 10; k++) begin
            out_valid = 1'b1;
            acc_out   = 32'h4100_0000 + 32'(k);
            if (k == 4) begin
                start = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd1; cfg_addr = 4'd1;
                cfg_wdata = 32'h1234_5678;
            end else begin
                start = 1'b0; cfg_we = 1'b0;
            end
            @(negedge clk);
            check($sformatf("recv_done[%0d]", k), {31'd0, done}, (k == 9) ? 1 : 0);
            check($sformatf("recv_busy[%0d]", k), {31'd0, busy}, (k <= 8) ? 1 : 0);
            check($sformatf("no_reburst[%0d]", k), {31'd0, in_valid_w}, 0);
        end
        out_valid = 1'b0; acc_out = '0; start = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 0);
        check("f1_errs", {30'd0, timeout_err, frame_err}, 0);
        for (int a = 0; a < 9; a++) begin
            rd_addr = a[3:0];
            @(negedge clk);
            check($sformatf("f1_res[%0d]", a), rd_data, 32'h4100_0000 + 32'(a));
        end
        rd_addr = 4'd12;
        @(negedge clk);
        check("rd_oob", rd_data, 0);

        // Frame 2: resend from unchanged buffers, accelerator silent -> timeout
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        for (int i = 0; i < 9; i++) begin
            chk_burst(i, c_U, c_W, c_V, 32'(i));
            @(negedge clk);
            cnt++;
        end
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("to_latency", 32'(cnt), 32'd74);
        check("to_err", {31'd0, timeout_err}, 1);
        check("to_frame_err", {31'd0, frame_err}, 0);
        @(negedge clk);
        check("to_done_pulse", {31'd0, done}, 0);

        // Frame 3: short 4-beat result burst
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("to_err_cleared", {31'd0, timeout_err}, 0);
        repeat (9) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            out_valid = 1'b1;
            acc_out   = 32'h5200_0000 + 32'(k);
            @(negedge clk);
        end
        out_valid = 1'b0; acc_out = '0;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("short_done", {31'd0, done}, 1);
        check("short_frame_err", {31'd0, frame_err}, 1);
        for (int a = 0; a < 9; a++) begin
            rd_addr = a[3:0];
            @(negedge clk);
            check($sformatf("f3_res[%0d]", a), rd_data,
                  (a < 4) ? 32'h5200_0000 + 32'(a) : 32'h4100_0000 + 32'(a));
        end

        // Frame 4: reset dropped at SEND idx 4
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fr_err_cleared", {31'd0, frame_err}, 0);
        repeat (4) @(negedge clk);
        check("idx4_x", data_x, 32'd4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valids", {28'd0, in_valid_u, in_valid_w, in_valid_v, in_valid_x}, 0);
        check("mid_rst_bus", weight_u | weight_w | weight_v | data_x, 0);
        check("mid_rst_flags", {28'd0, busy, done, timeout_err, frame_err}, 0);
        check("mid_rst_rd", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr = 4'd0;
        @(negedge clk);
        check("post_rst_res", rd_data, 0);
        check("post_rst_busy", {31'd0, busy}, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_valid", {31'd0, in_valid_v}, 1);
        check("post_rst_buf", weight_v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rnn_host_ctrl.md
# rnn_host_ctrl

Host-side driver/collector for the 3x3 simple-RNN accelerator. Holds one frame of U, W, V weights and X data (9 IEEE-754 single-precision words each) loaded by software, streams it to the accelerator with the 9-cycle `in_valid` burst protocol, then captures the 9-word result burst into a readable result buffer. It sits between the host configuration bus and the accelerator core. It is the transmitting end of the accelerator's input interface and the receiving end of its output interface.

## Interface
- DATA_W, 32, word width (IEEE-754 single)
- N_ELEM, 9, words per vector/burst
- TIMEOUT, 63, max cycles in WAIT without `out_valid` before abort
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  buffer write strobe (ignored while busy)
- cfg_sel  in  2  target buffer: 0=U, 1=W, 2=V, 3=X
- cfg_addr  in  4  element index 0..8; writes to 9..15 are dropped
- cfg_wdata  in  DATA_W  write data
- start  in  1  launch pulse (ignored while busy)
- busy  out  1  high in SEND/WAIT/RECV/DONE
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  sticky; set on timeout, cleared on accepted start
- frame_err  out  1  sticky; set on short output burst, cleared on accepted start
- rd_addr  in  4  result index
- rd_data  out  DATA_W  registered result read; 0 for rd_addr>8
- in_valid_u, in_valid_w, in_valid_v, in_valid_x  out  1  accelerator input valids (always equal)
- weight_u, weight_w, weight_v, data_x  out  DATA_W  accelerator input words
- out_valid  in  1  accelerator result valid
- out  in  DATA_W  accelerator result word

## Operation
- FSM states: IDLE, SEND, WAIT, RECV, DONE.
- IDLE: `cfg_we` writes buffer[cfg_sel][cfg_addr]. Accepted `start` clears both error flags, clears the index, and moves to SEND.
- SEND: drive element idx (0..8) of U/W/V/X with all four valids high. After idx 8, go to WAIT.
- WAIT: wait counter increments each cycle while `out_valid`=0.
  - `out_valid`=1: capture `out` into res[0], set k=1, go to RECV.
  - Counter reaches TIMEOUT-1 with `out_valid`=0: set timeout_err, go to DONE.
- RECV: each cycle with `out_valid`=1, capture res[k] and increment k.
  - Capture of res[8]: go to DONE.
  - `out_valid`=0 before 9 captures: set frame_err, go to DONE. Uncaptured res entries keep their old values.
- DONE: assert done for one cycle, then go to IDLE. In DONE and IDLE, `out_valid` beats beyond the 9th are ignored.
- `out_valid`=1 during SEND is ignored.
- Input buffers persist across frames, so a frame can be resent by asserting start alone.
- `rd_data` <= res[rd_addr] every cycle in every state.
- Data are pass-through only. No arithmetic on words.

## Timing
- All outputs are registered.
- Reset values: every output 0, FSM in IDLE, all buffers and res zeroed.
- `start` is sampled high at edge t. Valids are high on cycles t+1..t+9 carrying idx 0..8. Valids are low from t+10 on.
- While valids are low, weight_*/data_x are driven to 0.
- Result capture uses the same edge at which `out_valid`=1 is sampled.
- `done` goes high one cycle after the edge that captures res[8].
- Timeout: with no `out_valid`, done is high TIMEOUT+1 cycles after WAIT entry.
- `rd_data` latency is 1 cycle.
- `cfg_we` together with `start` in IDLE: the write is performed and the start is accepted.
- `rst_n` asserted mid-frame: immediate return to reset values; buffers are lost.

## Structure
- Package `rnn_pkg` holds:
  - DATA_W, N_ELEM
  - state enum {IDLE, SEND, WAIT, RECV, DONE}
  - cfg_sel encodings SEL_U/SEL_W/SEL_V/SEL_X
  - FP_ZERO constant
- Sub-module `rnn_vec_buf`: a 9 x DATA_W register file with one write port and one combinational read port. It is instantiated five times: U, W, V, X, and the result buffer.

## Test plan
- Load U[i]=0x3F800000, W[i]=0x40000000, V[i]=0x40400000, X[i]=i, pulse start -> valids high exactly 9 cycles, each bus shows the expected word at idx 0..8, busy=1.
- Model returns out=0x41000000+k for 9 consecutive cycles starting 5 cycles after the burst -> res[k] captured in order, done pulses once, reading rd_addr=0..8 gives the values with 1-cycle latency, rd_addr=12 gives 0.
- Model never asserts out_valid -> timeout_err=1, done pulses at WAIT entry + 64 cycles, next start clears timeout_err.
- Model asserts out_valid for only 4 cycles -> frame_err=1, res[0..3] updated, res[4..8] unchanged, done pulses.
- start and cfg_we pulsed during SEND/RECV -> no second burst, buffers unchanged. Model holds out_valid for 10 cycles -> 10th beat ignored.
- rst_n dropped at SEND idx 4 -> all outputs 0 immediately, FSM in IDLE, reading res returns 0.
